// File: rtl/avr_hvpp_pkg.sv
// Shared op codes, state encoding and pin bundle for the AVR HVPP command sequencer.
package avr_hvpp_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PHASE_W   = 8;
  localparam int unsigned RDY_CNT_W = 16;

  localparam logic [OP_W-1:0] OP_LOAD_CMD     = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD_ADDR_LO = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD_ADDR_HI = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD_DATA_LO = 3'd3;
  localparam logic [OP_W-1:0] OP_LOAD_DATA_HI = 3'd4;
  localparam logic [OP_W-1:0] OP_PAGEL        = 3'd5;
  localparam logic [OP_W-1:0] OP_WRITE        = 3'd6;
  localparam logic [OP_W-1:0] OP_READ         = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XTAL_HI,
    ST_XTAL_LO,
    ST_PL_HI,
    ST_PL_LO,
    ST_WR_LO,
    ST_BLANK,
    ST_WAIT_RDY,
    ST_OE_LO,
    ST_SAMPLE
  } state_e;

  typedef struct packed {
    logic xa1;
    logic xa0;
    logic bs1;
  } xa_bs_t;

  // Registered image of every line driven towards the target device
  typedef struct packed {
    logic              xtal;
    logic              xa0;
    logic              xa1_bs2;
    logic              pagel_bs1;
    logic              wr_n;
    logic              oe_n;
    logic [DATA_W-1:0] dout;
  } pins_t;

  localparam pins_t PINS_RESET = '{xtal: 1'b0, xa0: 1'b0, xa1_bs2: 1'b0, pagel_bs1: 1'b0,
                                   wr_n: 1'b1, oe_n: 1'b1, dout: '0};

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op <= OP_LOAD_DATA_HI;
  endfunction

  // XA1/XA0/BS1 selection for each load primitive
  function automatic xa_bs_t load_enc(input logic [OP_W-1:0] op);
    xa_bs_t e;
    case (op)
      OP_LOAD_CMD:     e = '{xa1: 1'b1, xa0: 1'b0, bs1: 1'b0};
      OP_LOAD_ADDR_LO: e = '{xa1: 1'b0, xa0: 1'b0, bs1: 1'b0};
      OP_LOAD_ADDR_HI: e = '{xa1: 1'b0, xa0: 1'b0, bs1: 1'b1};
      OP_LOAD_DATA_LO: e = '{xa1: 1'b0, xa0: 1'b1, bs1: 1'b0};
      OP_LOAD_DATA_HI: e = '{xa1: 1'b0, xa0: 1'b1, bs1: 1'b1};
      default:         e = '{xa1: 1'b0, xa0: 1'b0, bs1: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/avr_hvpp_sequencer_if.sv
// Host-side command/response handshake of the HVPP sequencer.
interface avr_hvpp_sequencer_if;
  import avr_hvpp_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

endinterface

// File: rtl/avr_hvpp_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avr_hvpp_sequencer.sv
// Turns one-byte HVPP primitives into timed XTAL/WR/OE/PAGEL pulses and waits on RDY/BSY.
module avr_hvpp_sequencer
  import avr_hvpp_pkg::*;
#(
  parameter int unsigned XTAL_HALF   = 4,
  parameter int unsigned WR_PULSE    = 8,
  parameter int unsigned RDY_TIMEOUT = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  avr_hvpp_sequencer_if.slave      bus,
  output logic                     dut_xtal,
  output logic                     dut_xa0,
  output logic                     dut_xa1_bs2,
  output logic                     dut_pagel_bs1,
  output logic                     dut_wr_n,
  output logic                     dut_oe_n,
  output logic [DATA_W-1:0]        dut_dout,
  output logic                     dut_dout_oe,
  input  logic [DATA_W-1:0]        dut_din,
  input  logic                     dut_rdy
);

  localparam logic [PHASE_W-1:0]   HALF_LD  = PHASE_W'(XTAL_HALF - 1);
  localparam logic [PHASE_W-1:0]   WR_LD    = PHASE_W'(WR_PULSE - 1);
  localparam logic [PHASE_W-1:0]   BLANK_LD = PHASE_W'(1);
  localparam logic [RDY_CNT_W-1:0] RDY_LAST = RDY_CNT_W'(RDY_TIMEOUT - 1);

  state_e                 state, state_nx;
  logic [PHASE_W-1:0]     cnt, cnt_nx;
  logic [RDY_CNT_W-1:0]   rdy_cnt, rdy_cnt_nx;
  logic [OP_W-1:0]        op_q, op_nx;
  pins_t                  pins, pins_nx;
  logic [DATA_W-1:0]      din_q, din_nx;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_nx;
  logic                   rsp_valid_q, rsp_valid_nx;
  logic                   rsp_timeout_q, rsp_timeout_nx;
  logic                   cmd_ready_q, cmd_ready_nx;
  logic                   busy_q;
  logic                   rdy_s;
  logic                   phase_done;
  xa_bs_t                 enc;

  sync2 u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_rdy),
    .q     (rdy_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rdy_cnt       <= '0;
      op_q          <= '0;
      pins          <= PINS_RESET;
      din_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      rdy_cnt       <= rdy_cnt_nx;
      op_q          <= op_nx;
      pins          <= pins_nx;
      din_q         <= din_nx;
      rsp_data_q    <= rsp_data_nx;
      rsp_valid_q   <= rsp_valid_nx;
      rsp_timeout_q <= rsp_timeout_nx;
      cmd_ready_q   <= cmd_ready_nx;
      busy_q        <= !cmd_ready_nx;
    end
  end

  // Next state; pin levels are derived from the next state so they are registered
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    rdy_cnt_nx     = rdy_cnt;
    op_nx          = op_q;
    pins_nx        = pins;
    din_nx         = din_q;
    rsp_data_nx    = rsp_data_q;
    rsp_valid_nx   = 1'b0;
    rsp_timeout_nx = 1'b0;
    enc            = load_enc(bus.cmd_op);
    phase_done     = (cnt == '0);

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_nx    = bus.cmd_op;
          state_nx = ST_SETUP;
          cnt_nx   = HALF_LD;
          if (is_load(bus.cmd_op)) begin
            pins_nx.xa1_bs2   = enc.xa1;
            pins_nx.xa0       = enc.xa0;
            pins_nx.pagel_bs1 = enc.bs1;
            pins_nx.dout      = bus.cmd_data;
          end else if (bus.cmd_op == OP_PAGEL) begin
            pins_nx.pagel_bs1 = 1'b0;
          end else begin
            pins_nx.pagel_bs1 = bus.cmd_data[0];
            pins_nx.xa1_bs2   = bus.cmd_data[1];
          end
        end
      end
      ST_SETUP: begin
        if (phase_done) begin
          cnt_nx = HALF_LD;
          if (is_load(op_q)) begin
            state_nx = ST_XTAL_HI;
          end else if (op_q == OP_PAGEL) begin
            state_nx          = ST_PL_HI;
            pins_nx.pagel_bs1 = 1'b1;
          end else if (op_q == OP_WRITE) begin
            state_nx = ST_WR_LO;
            cnt_nx   = WR_LD;
          end else begin
            state_nx = ST_OE_LO;
          end
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      ST_XTAL_HI, ST_PL_HI: begin
        if (phase_done) begin
          state_nx          = (state == ST_PL_HI) ? ST_PL_LO : ST_XTAL_LO;
          cnt_nx            = HALF_LD;
          pins_nx.pagel_bs1 = (state == ST_PL_HI) ? 1'b0 : pins.pagel_bs1;
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      ST_XTAL_LO, ST_PL_LO: begin
        if (phase_done) begin
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      ST_WR_LO: begin
        if (phase_done) begin
          state_nx = ST_BLANK;
          cnt_nx   = BLANK_LD;
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      ST_BLANK: begin
        if (phase_done) begin
          state_nx   = ST_WAIT_RDY;
          rdy_cnt_nx = '0;
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      // RDY seen in the last allowed cycle still counts as success
      ST_WAIT_RDY: begin
        if (rdy_s) begin
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b1;
        end else if (rdy_cnt == RDY_LAST) begin
          state_nx       = ST_IDLE;
          rsp_valid_nx   = 1'b1;
          rsp_timeout_nx = 1'b1;
        end else begin
          rdy_cnt_nx = rdy_cnt + RDY_CNT_W'(1);
        end
      end
      ST_OE_LO: begin
        if (phase_done) begin
          state_nx = ST_SAMPLE;
          din_nx   = dut_din;
        end else begin
          cnt_nx = cnt - PHASE_W'(1);
        end
      end
      ST_SAMPLE: begin
        state_nx     = ST_IDLE;
        rsp_valid_nx = 1'b1;
        rsp_data_nx  = din_q;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    pins_nx.xtal = (state_nx == ST_XTAL_HI);
    pins_nx.wr_n = (state_nx != ST_WR_LO);
    pins_nx.oe_n = (state_nx != ST_OE_LO);
    cmd_ready_nx = (state_nx == ST_IDLE);
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign dut_xtal      = pins.xtal;
  assign dut_xa0       = pins.xa0;
  assign dut_xa1_bs2   = pins.xa1_bs2;
  assign dut_pagel_bs1 = pins.pagel_bs1;
  assign dut_wr_n      = pins.wr_n;
  assign dut_oe_n      = pins.oe_n;
  assign dut_dout      = pins.dout;
  assign dut_dout_oe   = pins.oe_n;

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// Directed bench for avr_hvpp_sequencer with a response scoreboard and cycle-accurate pin monitor.
module tb_avr_hvpp_sequencer;

  logic       clk;
  logic       rst_n;
  logic       dut_xtal, dut_xa0, dut_xa1_bs2, dut_pagel_bs1;
  logic       dut_wr_n, dut_oe_n, dut_dout_oe;
  logic [7:0] dut_dout;
  logic [7:0] dut_din;
  logic       dut_rdy;

  avr_hvpp_sequencer_if bus ();

  avr_hvpp_sequencer #(
    .XTAL_HALF   (4),
    .WR_PULSE    (8),
    .RDY_TIMEOUT (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .dut_xtal      (dut_xtal),
    .dut_xa0       (dut_xa0),
    .dut_xa1_bs2   (dut_xa1_bs2),
    .dut_pagel_bs1 (dut_pagel_bs1),
    .dut_wr_n      (dut_wr_n),
    .dut_oe_n      (dut_oe_n),
    .dut_dout      (dut_dout),
    .dut_dout_oe   (dut_dout_oe),
    .dut_din       (dut_din),
    .dut_rdy       (dut_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor slots: 0 xtal high, 1 wr_n low, 2 oe_n low, 3 pagel_bs1 high
  int   mon_n[4];
  int   mon_f[4];
  int   mon_l[4];
  int   oe_mis;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a command, wait for acceptance, return in cycle 1 after the accept edge
  task automatic issue(input logic [2:0] op, input logic [7:0] d,
                       input logic [7:0] exp_data, input logic exp_tmo);
    exp_t e;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && bus.cmd_ready !== 1'b1; i++) tick();
    e.data = exp_data;
    e.tmo  = exp_tmo;
    sb.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Step from cycle 1 until rsp_valid, recording pin activity and scoring the response
  task automatic watch(input int max_cyc, input int rdy_rise, output int rsp_c);
    logic [3:0] act;
    exp_t       e;
    bit         done;
    rsp_c  = -1;
    done   = 0;
    oe_mis = 0;
    for (int k = 0; k < 4; k++) begin
      mon_n[k] = 0;
      mon_f[k] = -1;
      mon_l[k] = -1;
    end
    for (int c = 1; c <= max_cyc && !done; c++) begin
      if (c == rdy_rise) dut_rdy = 1'b1;
      act = {dut_pagel_bs1 === 1'b1, dut_oe_n === 1'b0, dut_wr_n === 1'b0, dut_xtal === 1'b1};
      for (int k = 0; k < 4; k++) begin
        if (act[k]) begin
          mon_n[k]++;
          if (mon_f[k] < 0) mon_f[k] = c;
          mon_l[k] = c;
        end
      end
      if (dut_dout_oe !== dut_oe_n) oe_mis++;
      if (bus.rsp_valid === 1'b1) begin
        rsp_c = c;
        done  = 1;
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_timeout", bus.rsp_timeout, e.tmo);
        end
      end else begin
        tick();
      end
    end
    if (!done) chk("rsp_valid_seen", 32'd0, 32'd1);
  endtask

  logic [2:0] ld_op  [5] = '{3'd4, 3'd1, 3'd0, 3'd3, 3'd2};
  logic [7:0] ld_dat [5] = '{8'hC3, 8'h3C, 8'h40, 8'h81, 8'h07};
  logic [2:0] ld_enc [5] = '{3'b011, 3'b000, 3'b100, 3'b010, 3'b001};  // {xa1, xa0, bs1}

  initial begin
    int         rc;
    int         nrsp;
    logic [7:0] last_read;
    logic [2:0] e3;

    last_read     = 8'h00;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h00;
    dut_din       = 8'h00;
    dut_rdy       = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_xtal", dut_xtal, 1'b0);
    chk("rst_xa0", dut_xa0, 1'b0);
    chk("rst_xa1_bs2", dut_xa1_bs2, 1'b0);
    chk("rst_pagel_bs1", dut_pagel_bs1, 1'b0);
    chk("rst_wr_n", dut_wr_n, 1'b1);
    chk("rst_oe_n", dut_oe_n, 1'b1);
    chk("rst_dout_oe", dut_dout_oe, 1'b1);
    chk("rst_dout", dut_dout, 8'h00);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);

    // All five load primitives: line encoding, data, XTAL window and latency
    for (int i = 0; i < 5; i++) begin
      issue(ld_op[i], ld_dat[i], last_read, 1'b0);
      chk("load_busy", bus.busy, 1'b1);
      watch(100, -1, rc);
      e3 = ld_enc[i];
      chk("load_rsp_cycle", rc, 13);
      chk("load_xtal_first", mon_f[0], 5);
      chk("load_xtal_last", mon_l[0], 8);
      chk("load_xtal_len", mon_n[0], 4);
      chk("load_wr_idle", mon_n[1], 0);
      chk("load_xa1", dut_xa1_bs2, e3[2]);
      chk("load_xa0", dut_xa0, e3[1]);
      chk("load_bs1", dut_pagel_bs1, e3[0]);
      chk("load_dout", dut_dout, ld_dat[i]);
      chk("load_ready_at_rsp", bus.cmd_ready, 1'b1);
      tick();
      chk("load_rsp_one_cycle", bus.rsp_valid, 1'b0);
    end

    // WRITE with RDY returning at cycle 20
    dut_rdy = 1'b0;
    issue(3'd6, 8'h01, last_read, 1'b0);
    watch(300, 20, rc);
    chk("wr_rsp_cycle", rc, 23);
    chk("wr_pulse_len", mon_n[1], 8);
    chk("wr_pulse_first", mon_f[1], 5);
    chk("wr_pulse_last", mon_l[1], 12);
    chk("wr_no_xtal", mon_n[0], 0);
    chk("wr_bs1", dut_pagel_bs1, 1'b1);
    chk("wr_bs2", dut_xa1_bs2, 1'b0);
    tick();

    // WRITE with RDY stuck low: times out after 100 WAIT_RDY cycles
    dut_rdy = 1'b0;
    issue(3'd6, 8'h02, last_read, 1'b1);
    watch(400, -1, rc);
    chk("tmo_rsp_cycle", rc, 115);
    chk("tmo_pulse_len", mon_n[1], 8);
    chk("tmo_pulse_last", mon_l[1], 12);
    chk("tmo_bs2", dut_xa1_bs2, 1'b1);
    dut_rdy = 1'b1;
    tick();
    chk("tmo_flag_clears", bus.rsp_timeout, 1'b0);

    // READ with BS2=1, BS1=0
    dut_din   = 8'hA5;
    last_read = 8'hA5;
    issue(3'd7, 8'h02, last_read, 1'b0);
    watch(100, -1, rc);
    chk("rd_rsp_cycle", rc, 10);
    chk("rd_oe_len", mon_n[2], 4);
    chk("rd_oe_first", mon_f[2], 5);
    chk("rd_oe_last", mon_l[2], 8);
    chk("rd_dout_oe_tracks", oe_mis, 0);
    chk("rd_bs2", dut_xa1_bs2, 1'b1);
    chk("rd_bs1", dut_pagel_bs1, 1'b0);
    chk("rd_oe_released", dut_oe_n, 1'b1);
    dut_din = 8'h00;
    tick();
    chk("rd_rsp_hold", bus.rsp_data, 8'hA5);

    // LOAD_CMD then PAGEL with cmd_valid held high throughout
    begin
      exp_t e;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'h10;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 300 && bus.cmd_ready !== 1'b1; i++) tick();
      e.data = last_read;
      e.tmo  = 1'b0;
      sb.push_back(e);
      tick();
      bus.cmd_op   = 3'd5;
      bus.cmd_data = 8'h00;
      watch(100, -1, rc);
      chk("b2b_first_rsp_cycle", rc, 13);
      chk("b2b_ready_with_rsp", bus.cmd_ready, 1'b1);
      chk("b2b_xa1", dut_xa1_bs2, 1'b1);
      chk("b2b_xa0", dut_xa0, 1'b0);
      chk("b2b_dout", dut_dout, 8'h10);
      sb.push_back(e);
      tick();
      bus.cmd_valid = 1'b0;
      chk("b2b_second_accepted", bus.busy, 1'b1);
      chk("b2b_rsp_one_cycle", bus.rsp_valid, 1'b0);
      watch(100, -1, rc);
      chk("pagel_rsp_cycle", rc, 13);
      chk("pagel_len", mon_n[3], 4);
      chk("pagel_first", mon_f[3], 5);
      chk("pagel_low_after", dut_pagel_bs1, 1'b0);
      tick();
    end

    // Reset asserted while WR is low
    dut_rdy = 1'b0;
    issue(3'd6, 8'h03, last_read, 1'b0);
    for (int i = 0; i < 20 && dut_wr_n !== 1'b0; i++) tick();
    chk("abort_wr_active", dut_wr_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_n", dut_wr_n, 1'b1);
    chk("abort_ready", bus.cmd_ready, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_bs_lines", {dut_xa1_bs2, dut_pagel_bs1}, 2'b00);
    chk("abort_rsp_data", bus.rsp_data, 8'h00);
    sb.delete();
    last_read = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    nrsp  = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid === 1'b1) nrsp++;
      tick();
    end
    chk("abort_no_rsp", nrsp, 0);
    chk("abort_idle", bus.cmd_ready, 1'b1);
    dut_rdy = 1'b1;

    // Recovery: a load after reset completes normally
    issue(3'd3, 8'h99, last_read, 1'b0);
    watch(100, -1, rc);
    chk("recover_rsp_cycle", rc, 13);
    chk("recover_dout", dut_dout, 8'h99);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
